// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TX/RX data registers, a control/status
// register and a level interrupt, on the CPU MEM-stage load/store bus.
module uart_mmio #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter logic [31:0] BASE     = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int unsigned      CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [31:0]      ADDR_TXD  = BASE;
    localparam logic [31:0]      ADDR_RXD  = BASE + 32'd4;
    localparam logic [31:0]      ADDR_CON  = BASE + 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    logic [7:0]       tx_byte;
    logic [7:0]       rx_data;
    logic [7:0]       rx_shift;
    logic             tx_irq_en;
    logic             rx_irq_en;
    logic             rx_ready;
    logic             tx_done;
    logic             tx_busy;
    logic             overrun;
    logic             frame_err;
    uart_state_e      tx_state;
    uart_state_e      rx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       tx_bit;
    logic [2:0]       rx_bit;
    logic             tx_last;
    logic             rx_sync1;
    logic             rx_sync2;
    logic             rx_prev;

    logic             tx_start_c;
    logic             rd_rxd_c;
    logic             rd_con_c;
    logic             wr_con_c;
    logic             rx_sample_c;
    logic [6:0]       con_c;
    logic             unused_wdata_c;

    // Bus decode and strobes
    always_comb begin
        tx_start_c     = wr && (addr == ADDR_TXD) && !tx_busy;
        wr_con_c       = wr && (addr == ADDR_CON);
        rd_rxd_c       = rd && (addr == ADDR_RXD);
        rd_con_c       = rd && (addr == ADDR_CON);
        rx_sample_c    = (rx_state == ST_STOP) && (rx_cnt == BIT_LAST);
        con_c          = {frame_err, overrun, tx_busy, tx_done, rx_ready, rx_irq_en, tx_irq_en};
        unused_wdata_c = ^wdata[31:8];
    end

    // Combinational read mux; zero when idle or unmapped
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            if (addr == ADDR_TXD)      rdata = {24'd0, tx_byte};
            else if (addr == ADDR_RXD) rdata = {24'd0, rx_data};
            else if (addr == ADDR_CON) rdata = {25'd0, con_c};
        end
    end

    // TX FSM; line output lags the state by one edge, as does the end-of-frame pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_last  <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            tx_last <= 1'b0;
            case (tx_state)
                ST_IDLE: begin
                    if (tx_start_c) begin
                        tx_state <= ST_START;
                        tx_cnt   <= '0;
                        tx_bit   <= 3'd0;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) tx_state <= ST_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= ST_IDLE;
                        tx_last  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
            case (tx_state)
                ST_START: uart_txd <= 1'b0;
                ST_DATA:  uart_txd <= tx_byte[tx_bit];
                default:  uart_txd <= 1'b1;
            endcase
        end
    end

    // RX synchroniser and FSM: mid-bit sampling from a half-bit start check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_sync1 <= uart_rxd;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync2) begin
                        rx_state <= ST_START;
                        rx_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    // Software-visible registers, read side effects and interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_byte   <= 8'd0;
            rx_data   <= 8'd0;
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
            rx_ready  <= 1'b0;
            tx_done   <= 1'b0;
            tx_busy   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irqout    <= 1'b0;
        end else begin
            if (tx_start_c) begin
                tx_byte <= wdata[7:0];
                tx_busy <= 1'b1;
            end
            if (tx_last) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
            end else if (rd_con_c) begin
                tx_done <= 1'b0;
            end
            if (wr_con_c) begin
                tx_irq_en <= wdata[0];
                rx_irq_en <= wdata[1];
            end
            // A new byte beats a same-edge RXD read; that read consumed the old byte
            if (rx_sample_c) begin
                rx_data   <= rx_shift;
                rx_ready  <= 1'b1;
                frame_err <= !rx_sync2;
                overrun   <= rx_ready && !rd_rxd_c;
            end else if (rd_rxd_c) begin
                rx_ready  <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            irqout <= (tx_irq_en && tx_done) || (rx_irq_en && rx_ready);
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed, table-driven bench for uart_mmio at BAUD_DIV=16.
module tb_uart_mmio;

    localparam int unsigned BD     = 16;
    localparam logic [31:0] BASE   = 32'h4000_0018;
    localparam logic [31:0] A_TXD  = BASE;
    localparam logic [31:0] A_RXD  = BASE + 32'd4;
    localparam logic [31:0] A_CON  = BASE + 32'd8;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irqout;
    logic        uart_rxd;
    logic        uart_txd;

    int checks = 0;
    int errors = 0;

    vec_t tbl_rst [6];
    vec_t tbl_tx  [7];

    uart_mmio #(.BAUD_DIV(BD), .BASE(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irqout   (irqout),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read between edges with rd dropped before the next posedge: no side effects
    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        rd   = 1'b1;
        addr = a;
        #1;
        v    = rdata;
        rd   = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        addr = a;
        rd   = 1'b1;
        #1;
        v    = rdata;
        @(negedge clk);
        rd   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_table(input string nm, input vec_t t [], input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd   = t[i].rd;
            addr = t[i].addr;
            #1;
            check($sformatf("%s[%0d]", nm, i), rdata, t[i].exp);
            rd   = 1'b0;
        end
    endtask

    // Called at the negedge just after the accepting edge N; checks first and
    // last cycle of each bit, busy/done around the frame end and the interrupt.
    task automatic tx_frame(input logic [7:0] b, input logic inject, input logic [1:0] en,
                            input logic rd_at_done, input string nm);
        logic [9:0]  fr;
        logic [31:0] v;
        logic [31:0] enx;
        int          k;
        int          p;
        fr  = {1'b1, b, 1'b0};
        enx = {30'd0, en};
        check({nm, " idle before"}, {31'd0, uart_txd}, 32'd1);
        for (int c = 1; c <= 162; c++) begin
            @(negedge clk);
            wr = 1'b0;
            if (c <= 160) begin
                k = (c - 1) / 16;
                p = (c - 1) % 16;
                if (p == 0 || p == 15)
                    check($sformatf("%s bit%0d c%0d", nm, k, c), {31'd0, uart_txd}, {31'd0, fr[k[3:0]]});
            end
            if (c == 80) begin
                peek(A_CON, v);
                check({nm, " CON mid"}, v, 32'h10 | enx);
            end
            if (c == 160) begin
                if (rd_at_done) begin
                    rd   = 1'b1;
                    addr = A_CON;
                    #1;
                    check({nm, " CON read at done edge"}, rdata, 32'h10 | enx);
                end else begin
                    peek(A_CON, v);
                    check({nm, " CON last cycle"}, v, 32'h10 | enx);
                end
            end
            if (c == 161) begin
                rd = 1'b0;
                peek(A_CON, v);
                check({nm, " CON after"}, v, 32'h08 | enx);
            end
            if (c == 162)
                check({nm, " irqout"}, {31'd0, irqout}, {31'd0, en[0]});
            if (inject && c == 20) begin
                addr  = A_TXD;
                wdata = 32'h0000_00FF;
                wr    = 1'b1;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BD) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (BD) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int          lows;

        tbl_rst[0] = '{1'b1, A_TXD,          32'h0};
        tbl_rst[1] = '{1'b1, A_RXD,          32'h0};
        tbl_rst[2] = '{1'b1, A_CON,          32'h0};
        tbl_rst[3] = '{1'b1, 32'h4000_0030,  32'h0};
        tbl_rst[4] = '{1'b1, BASE - 32'd4,   32'h0};
        tbl_rst[5] = '{1'b0, A_CON,          32'h0};

        tbl_tx[0]  = '{1'b1, A_TXD,          32'h0000_00A5};
        tbl_tx[1]  = '{1'b0, A_TXD,          32'h0};
        tbl_tx[2]  = '{1'b1, A_RXD,          32'h0};
        tbl_tx[3]  = '{1'b1, A_CON,          32'h0000_0008};
        tbl_tx[4]  = '{1'b1, BASE + 32'd1,   32'h0};
        tbl_tx[5]  = '{1'b1, 32'h0000_0018,  32'h0};
        tbl_tx[6]  = '{1'b1, 32'h5000_0020,  32'h0};

        rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        uart_rxd = 1'b1; reset = 1'b0;

        // Reset held: clock and RX line toggling must not disturb anything
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            uart_rxd = ~uart_rxd;
        end
        uart_rxd = 1'b1;
        check("rst txd", {31'd0, uart_txd}, 32'd1);
        check("rst irq", {31'd0, irqout}, 32'd0);
        run_table("rst", tbl_rst, 6);
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // TX frame of A5, no interrupt enabled
        bus_write(A_TXD, 32'h0000_00A5);
        tx_frame(8'hA5, 1'b0, 2'b00, 1'b0, "txA5");
        bus_write(BASE + 32'd12, 32'h0000_0003);
        bus_write(A_RXD, 32'h0000_00FF);
        run_table("post_tx", tbl_tx, 7);
        bus_read(A_CON, v);
        check("CON read done", v, 32'h08);
        peek(A_CON, v);
        check("CON done cleared", v, 32'h00);

        // Busy write ignored; tx interrupt until CON read
        bus_write(A_CON, 32'h0000_0001);
        bus_write(A_TXD, 32'h0000_003C);
        tx_frame(8'h3C, 1'b1, 2'b01, 1'b0, "tx3C");
        bus_read(A_TXD, v);
        check("TXD after busy write", v, 32'h3C);
        bus_read(A_CON, v);
        check("CON tx irq", v, 32'h09);
        check("irq held on read edge", {31'd0, irqout}, 32'd1);
        idle(1);
        check("irq dropped", {31'd0, irqout}, 32'd0);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!uart_txd) lows++;
        end
        check("no second frame", 32'(lows), 32'd0);

        // RX byte with rx interrupt
        bus_write(A_CON, 32'h0000_0002);
        send_rx(8'h5A, 1'b1);
        idle(4);
        peek(A_CON, v);
        check("rx ready CON", v, 32'h06);
        check("rx irq", {31'd0, irqout}, 32'd1);
        bus_read(A_RXD, v);
        check("RXD 5A", v, 32'h5A);
        bus_read(A_CON, v);
        check("CON after RXD read", v, 32'h02);
        idle(1);
        check("rx irq dropped", {31'd0, irqout}, 32'd0);

        // Overrun
        send_rx(8'h11, 1'b1);
        idle(4);
        send_rx(8'h22, 1'b1);
        idle(4);
        peek(A_CON, v);
        check("overrun CON", v, 32'h26);
        bus_read(A_RXD, v);
        check("RXD overwritten", v, 32'h22);
        peek(A_CON, v);
        check("overrun cleared", v, 32'h02);

        // Frame error, byte still delivered
        send_rx(8'h33, 1'b0);
        idle(4);
        peek(A_CON, v);
        check("frame_err CON", v, 32'h46);
        bus_read(A_RXD, v);
        check("RXD framed-bad byte", v, 32'h33);
        peek(A_CON, v);
        check("frame_err cleared", v, 32'h02);

        // Short glitch must not produce a byte
        @(negedge clk);
        uart_rxd = 1'b0;
        idle(4);
        uart_rxd = 1'b1;
        idle(200);
        peek(A_CON, v);
        check("glitch ignored", v, 32'h02);
        check("glitch irq", {31'd0, irqout}, 32'd0);

        // Reset mid-TX aborts the frame
        bus_write(A_CON, 32'h0000_0000);
        bus_write(A_TXD, 32'h0000_0000);
        idle(50);
        check("txd low mid-frame", {31'd0, uart_txd}, 32'd0);
        reset = 1'b0;
        #1;
        check("txd after async reset", {31'd0, uart_txd}, 32'd1);
        peek(A_CON, v);
        check("CON in reset", v, 32'h00);
        @(negedge clk);
        reset = 1'b1;
        idle(200);
        peek(A_CON, v);
        check("no done after abort", v, 32'h00);
        check("txd idle after abort", {31'd0, uart_txd}, 32'd1);

        // Fresh frame after reset, with a CON read on the edge tx_done sets
        bus_write(A_TXD, 32'h0000_0081);
        tx_frame(8'h81, 1'b0, 2'b00, 1'b1, "tx81");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped 8N1 UART responder on the CPU data bus (rd/wr/addr/wdata/rdata), sitting beside data memory in the MEM stage. It accepts load/store requests from the pipeline, serialises bytes written by software onto the TX line, deserialises the RX line into a readable byte, and raises a level interrupt toward the CPU's IRQ input.

## Interface
Parameters:
- BAUD_DIV, 5208: clk cycles per bit (50 MHz / 9600). Must be ≥ 4.
- BASE, 32'h4000_0018: address of UART_TXD. UART_RXD is BASE+4; UART_CON is BASE+8.

Ports:
- clk  in  1  single clock. All state changes on posedge.
- reset  in  1  asynchronous, active-low. Low clears all state immediately.
- rd  in  1  bus read strobe, one cycle per load.
- wr  in  1  bus write strobe, one cycle per store.
- addr  in  32  word address. Decode is exact 32-bit match only.
- wdata  in  32  store data.
- rdata  out  32  combinational read data. 0 when rd=0 or addr is unmapped.
- irqout  out  1  level interrupt, registered.
- uart_rxd  in  1  asynchronous serial input, idle high.
- uart_txd  out  1  serial output, idle high, registered.

## Operation
Registers (read data zero-extended):
- UART_TXD (BASE): write [7:0] starts a frame only if tx_busy=0. A write while busy is ignored entirely. Read returns the last accepted byte.
- UART_RXD (BASE+4): read returns rx_data[7:0]. A read clears rx_ready and overrun at the next edge.
- UART_CON (BASE+8), bit layout:
  - [0] tx_irq_en (R/W)
  - [1] rx_irq_en (R/W)
  - [2] rx_ready (RO)
  - [3] tx_done (RO, sticky; cleared by a CON read)
  - [4] tx_busy (RO)
  - [5] overrun (RO)
  - [6] frame_err (RO; cleared by an RXD read)
  - A CON write updates [1:0] only.
- irqout <= (tx_irq_en & tx_done) | (rx_irq_en & rx_ready).
- Unmapped addresses: writes ignored, reads return 0.
- Read side effects take effect only at the posedge where rd=1 and the address matches.

TX FSM, states IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE:
- Each state lasts BAUD_DIV cycles, driven by a bit counter and a baud counter.
- Leaving STOP sets tx_done and clears tx_busy.

RX path:
- uart_rxd passes through a 2-FF synchroniser.
- RX FSM, states IDLE → START → DATA → STOP:
  - IDLE: a falling edge on the synchronised line enters START.
  - START: after BAUD_DIV/2 cycles, line still low → DATA; line high → glitch, back to IDLE.
  - DATA: samples 8 bits at BAUD_DIV intervals, LSB first.
  - STOP: sampled BAUD_DIV after the last data bit.
- On the stop sample:
  - rx_data is loaded and rx_ready is set.
  - frame_err is set if the stop bit is 0. The byte is still delivered.
  - overrun is set if rx_ready was already 1. The old byte is overwritten.
- RX returns to IDLE directly from the stop sample, with no wait for the full stop bit.

## Timing
- Reset values:
  - uart_txd=1, irqout=0.
  - rx_data=0, all CON bits 0, last TX byte 0.
  - Both FSMs in IDLE.
- Reset asserted mid-frame aborts immediately: uart_txd returns to 1 and no tx_done is produced.
- TX latency: write at edge N → uart_txd=0 from edge N+1. The full frame is exactly 10×BAUD_DIV cycles. tx_done=1 and tx_busy=0 at edge N+1+10×BAUD_DIV. irqout follows one edge later.
- A new TXD write accepted on the same edge tx_busy clears has no effect (busy is sampled before the edge). Software must see tx_busy=0 first.
- RX latency: rx_ready is set 2 (sync) + BAUD_DIV/2 + 9×BAUD_DIV cycles after the RX falling edge, ±1 cycle. irqout follows one edge later.
- Simultaneous events:
  - RXD read on the same edge as a new stop sample: the new byte wins, rx_ready stays 1, overrun=0 (the read consumed the old byte).
  - CON read on the same edge tx_done sets: tx_done stays 1.
- rdata is purely combinational from addr/rd and the current register state. This is required because the pipeline consumes load data in the same MEM cycle.

## Test plan
Benches use BAUD_DIV=16.
- Reset: hold reset low, toggle clk and uart_rxd. Expect uart_txd=1, irqout=0, CON reads 0, rdata=0 for addr 32'h4000_0030.
- TX frame: write 8'hA5 to TXD. Expect uart_txd sequence 0,1,0,1,0,0,1,0,1,1, 16 cycles each. CON reads 8'h10 mid-frame and 8'h08 after the frame. With tx_irq_en=1, irqout=1 until a CON read, then 0.
- Busy write: write 8'h3C, then 8'hFF 20 cycles later. The line carries only 8'h3C, and a TXD read returns 8'h3C.
- RX byte: drive frame 8'h5A with a good stop bit and rx_irq_en=1. Expect CON[2]=1 and irqout=1; RXD reads 8'h5A; the following CON read shows [2]=0 and irqout drops.
- RX errors:
  - Send 8'h11 then 8'h22 without reading. Expect RXD=8'h22 and overrun=1.
  - Send a frame with stop=0. Expect frame_err=1.
  - Send a 4-cycle low glitch. Expect no rx_ready.
- Reset mid-TX: assert reset 50 cycles into a frame. Expect uart_txd=1 immediately and tx_done=0. After release, a new write transmits normally.
